seq_div: RTL



---
 rtl/seq_div_pkg.sv | 21 ++
 rtl/div_step.sv | 30 +++
 rtl/seq_div.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and default widths for the seq_div restoring divider.
// The optional divide-by-zero fast path is enabled with SEQ_DIV_ZERO_CHK_EN.
package seq_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DIVIDEND_W_DEF = 18;
  localparam int DIVISOR_W_DEF  = 9;

  // Bit counter must hold DIVIDEND_W-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W_DEF = cnt_width(DIVIDEND_W_DEF);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// conditionally subtract the divisor and report the quotient bit.
module div_step
  import seq_div_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W-1:0] r_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] r_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] shifted_s;

  // Shift/compare/subtract. Incoming R is always below the divisor, so the
  // restored or reduced value fits back into DIVISOR_W bits.
  always_comb begin
    shifted_s = {r_in, bit_in};
    if (shifted_s >= {1'b0, divisor}) begin
      r_out = DIVISOR_W'(shifted_s - {1'b0, divisor});
      q_bit = 1'b1;
    end else begin
      r_out = shifted_s[DIVISOR_W-1:0];
      q_bit = 1'b0;
    end
  end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock with a
// start/done handshake. Define SEQ_DIV_ZERO_CHK_EN for the divide-by-zero fast path.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_err
);

  localparam int              CNT_W    = cnt_width(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIVIDEND_W - 1);

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [DIVIDEND_W-1:0]  dvd_r;
  logic [DIVISOR_W-1:0]   dvs_r;
  logic [DIVISOR_W-1:0]   rem_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   zero_r;
  logic                   zero_s;
  logic [DIVISOR_W-1:0]   rem_nxt_s;
  logic                   q_bit_s;
  logic                   accept_s;
  logic                   finish_s;

  // The dividend register doubles as the working quotient: bits leave at the MSB
  // and quotient bits enter at the LSB.
  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .r_in    (rem_r),
    .bit_in  (dvd_r[DIVIDEND_W-1]),
    .divisor (dvs_r),
    .r_out   (rem_nxt_s),
    .q_bit   (q_bit_s)
  );

`ifdef SEQ_DIV_ZERO_CHK_EN
  assign zero_s = (divisor == {DIVISOR_W{1'b0}});
`else
  assign zero_s = 1'b0;
`endif

  // Next-state and handshake decode; a flagged zero divisor leaves BUSY at once.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (zero_r || (cnt_r == {CNT_W{1'b0}})) begin
          finish_s    = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Working registers and result registers; results move only when done rises.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      dvd_r     <= {DIVIDEND_W{1'b0}};
      dvs_r     <= {DIVISOR_W{1'b0}};
      rem_r     <= {DIVISOR_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      zero_r    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= {DIVIDEND_W{1'b0}};
      remainder <= {DIVISOR_W{1'b0}};
      div_err   <= 1'b0;
    end else begin
      busy <= (state_nxt_s == ST_BUSY);
      done <= finish_s;
      if (accept_s) begin
        dvd_r  <= dividend;
        dvs_r  <= divisor;
        rem_r  <= {DIVISOR_W{1'b0}};
        cnt_r  <= CNT_LOAD;
        zero_r <= zero_s;
      end else if (state_r == ST_BUSY) begin
        dvd_r <= {dvd_r[DIVIDEND_W-2:0], q_bit_s};
        rem_r <= rem_nxt_s;
        cnt_r <= cnt_r - CNT_W'(1);
      end
      if (finish_s) begin
        if (zero_r) begin
          quotient  <= {DIVIDEND_W{1'b1}};
          remainder <= dvd_r[DIVISOR_W-1:0];
          div_err   <= 1'b1;
        end else begin
          quotient  <= {dvd_r[DIVIDEND_W-2:0], q_bit_s};
          remainder <= rem_nxt_s;
          div_err   <= 1'b0;
        end
      end
    end
  end

endmodule
